base_lane_unpack: RTL and testbench

Stream unpacker that accepts full-width multi-lane words and releases them to a consumer a variable number of lanes per cycle. It holds one word plus a lane offset and presents the unconsumed lanes right-justified at lane 0. It sits directly upstream of a variable-rate lane consumer such as a parser or narrowing stage, and drives a `base_shiftr_enc` instance with its offset.

---
 rtl/base_pkg.sv | 13 +
 rtl/base_shiftr_enc.sv | 28 ++
 rtl/base_lane_unpack.sv | 86 ++++++++
 tb/tb_base_lane_unpack.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/base_pkg.sv
// Shared helpers for the lane-oriented stream blocks: lane-count field sizing
// and an unsigned minimum used for clamping lane counts.
package base_pkg;

    function automatic int lane_cnt_w(input int ways);
        return $clog2(ways + 1);
    endfunction

    function automatic int unsigned min_cnt(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/base_shiftr_enc.sv
// Lane-granular right shifter with an encoded shift amount; lanes shifted in
// from above read as zero, and a shift of ways or more yields all zeros.
module base_shiftr_enc
    import base_pkg::*;
#(
    parameter int width     = 8,
    parameter int ways      = 4,
    parameter int oways     = ways,
    parameter int sel_width = lane_cnt_w(ways)
) (
    input  logic [ways*width-1:0]  i_d,
    input  logic [sel_width-1:0]   i_sel,
    output logic [oways*width-1:0] o_d
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        o_d = '0;
        for (int k = 0; k < oways; k++) begin
            int w_src;
            w_src = int'(i_sel) + k;
            if (w_src < ways) begin
                o_d[k*width +: width] = i_d[w_src*width +: width];
            end
        end
    end

endmodule

// File: rtl/base_lane_unpack.sv
// Holds one multi-lane word and releases it a variable number of lanes per
// cycle, presenting the unconsumed lanes right-justified at lane 0.
module base_lane_unpack
    import base_pkg::*;
#(
    parameter int width     = 8,
    parameter int ways      = 4,
    parameter int cnt_width = lane_cnt_w(ways)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_v,
    output logic                   i_r,
    input  logic [ways*width-1:0]  i_d,
    output logic                   o_v,
    output logic [cnt_width-1:0]   o_avail,
    output logic [ways*width-1:0]  o_d,
    input  logic [cnt_width-1:0]   o_take,
    output logic                   o_err
);

    localparam int OFF_W = $clog2(ways);
    localparam logic [cnt_width-1:0] WAYS_CNT = cnt_width'(ways);

    logic                  r_full;
    logic [OFF_W-1:0]      r_off;
    logic [ways*width-1:0] r_dreg;
    logic                  r_err;

    logic [cnt_width-1:0]  w_off_ext;
    logic [cnt_width-1:0]  w_avail;
    logic [cnt_width-1:0]  w_eff_take;
    logic [cnt_width-1:0]  w_sum;
    logic                  w_drain;
    logic                  w_load;
    logic [ways*width-1:0] w_shift;

    assign w_off_ext  = cnt_width'(r_off);
    assign w_avail    = r_full ? (WAYS_CNT - w_off_ext) : '0;
    assign w_eff_take = cnt_width'(min_cnt(32'(o_take), 32'(w_avail)));
    // The offset plus a clamped take never exceeds ways, so the sum fits cnt_width.
    assign w_sum      = w_off_ext + w_eff_take;
    assign w_drain    = r_full & (w_sum == WAYS_CNT);
    assign w_load     = i_v & i_r;

    assign i_r     = ~r_full | w_drain;
    assign o_v     = r_full;
    assign o_avail = w_avail;
    assign o_d     = r_full ? w_shift : '0;
    assign o_err   = r_err;

    base_shiftr_enc #(
        .width (width),
        .ways  (ways),
        .oways (ways)
    ) u_shift (
        .i_d   (r_dreg),
        .i_sel (w_off_ext),
        .o_d   (w_shift)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
            r_off  <= '0;
            // NOTE: the data register is reset too, so the held word is defined from the first cycle.
            r_dreg <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_full && (o_take > w_avail)) begin
                r_err <= 1'b1;
            end
            if (w_load) begin
                r_dreg <= i_d;
                r_off  <= '0;
                r_full <= 1'b1;
            end else if (w_drain) begin
                r_full <= 1'b0;
                r_off  <= '0;
            end else if (r_full && (w_eff_take != '0)) begin
                r_off <= r_off + OFF_W'(w_eff_take);
            end
        end
    end

endmodule

// File: tb/tb_base_lane_unpack.sv
// Cycle-by-cycle vector bench for base_lane_unpack (width=8, ways=4) with a
// scoreboard queue between the driver and the output monitor.
module tb_base_lane_unpack;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] d;
        logic [2:0]  take;
        logic        ir;
        logic        ov;
        logic [2:0]  av;
        logic [31:0] od;
        logic        err;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        i_v;
    logic        i_r;
    logic [31:0] i_d;
    logic        o_v;
    logic [2:0]  o_avail;
    logic [31:0] o_d;
    logic [2:0]  o_take;
    logic        o_err;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec;
    int   n_miscmp;
    int   n_seen;

    base_lane_unpack #(
        .width     (8),
        .ways      (4),
        .cnt_width (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_v     (i_v),
        .i_r     (i_r),
        .i_d     (i_d),
        .o_v     (o_v),
        .o_avail (o_avail),
        .o_d     (o_d),
        .o_take  (o_take),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset  = v.rst;
        i_v    = v.iv;
        i_d    = v.d;
        o_take = v.take;
        sb.push_back(v);
        n_vec++;
    endtask

    // Monitor: pops the expected record for the cycle just driven and compares.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("i_r",     n_seen, 32'(i_r),     32'(e.ir));
                check("o_v",     n_seen, 32'(o_v),     32'(e.ov));
                check("o_avail", n_seen, 32'(o_avail), 32'(e.av));
                check("o_d",     n_seen, o_d,          e.od);
                check("o_err",   n_seen, 32'(o_err),   32'(e.err));
                n_seen++;
            end
        end
    end

    initial begin
        logic [31:0] words [8];
        vec_t v;
        n_vec    = 0;
        n_miscmp = 0;
        n_seen   = 0;
        reset    = 1'b1;
        i_v      = 1'b0;
        i_d      = '0;
        o_take   = '0;
        repeat (2) @(posedge clk);

        //           rst   iv    d              take  ir    ov    av    od             err
        tbl.push_back('{1'b0, 1'b0, 32'h0,         3'd0, 1'b1, 1'b0, 3'd0, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h44332211,  3'd0, 1'b1, 1'b0, 3'd0, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,         3'd1, 1'b0, 1'b1, 3'd4, 32'h44332211,  1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,         3'd1, 1'b0, 1'b1, 3'd3, 32'h00443322,  1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,         3'd2, 1'b1, 1'b1, 3'd2, 32'h00004433,  1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'hDDCCBBAA,  3'd0, 1'b1, 1'b0, 3'd0, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h88776655,  3'd4, 1'b1, 1'b1, 3'd4, 32'hDDCCBBAA,  1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,         3'd4, 1'b1, 1'b1, 3'd4, 32'h88776655,  1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h44332211,  3'd0, 1'b1, 1'b0, 3'd0, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,         3'd3, 1'b0, 1'b1, 3'd4, 32'h44332211,  1'b0});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1'b0, 1'b1, 32'h99999999, 3'd0, 1'b0, 1'b1, 3'd1, 32'h00000044, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,         3'd1, 1'b1, 1'b1, 3'd1, 32'h00000044,  1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'hCAFEF00D,  3'd0, 1'b1, 1'b0, 3'd0, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,         3'd2, 1'b0, 1'b1, 3'd4, 32'hCAFEF00D,  1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,         3'd3, 1'b1, 1'b1, 3'd2, 32'h0000CAFE,  1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h0BADBEEF,  3'd0, 1'b1, 1'b0, 3'd0, 32'h0,         1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'h0,         3'd2, 1'b0, 1'b1, 3'd4, 32'h0BADBEEF,  1'b1});
        tbl.push_back('{1'b1, 1'b1, 32'h11111111,  3'd2, 1'b1, 1'b1, 3'd2, 32'h00000BAD,  1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'h0,         3'd7, 1'b1, 1'b0, 3'd0, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h5A5A1234,  3'd7, 1'b1, 1'b0, 3'd0, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,         3'd0, 1'b0, 1'b1, 3'd4, 32'h5A5A1234,  1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,         3'd4, 1'b1, 1'b1, 3'd4, 32'h5A5A1234,  1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,         3'd0, 1'b1, 1'b0, 3'd0, 32'h0,         1'b0});

        foreach (tbl[i]) apply(tbl[i]);

        // Streaming run: random words, full takes every cycle, no bubbles expected.
        for (int i = 0; i < 8; i++) words[i] = $urandom;
        for (int i = 0; i <= 8; i++) begin
            v.rst  = 1'b0;
            v.iv   = (i < 8);
            v.d    = (i < 8) ? words[i] : 32'h0;
            v.take = 3'd4;
            v.ir   = 1'b1;
            v.ov   = (i != 0);
            v.av   = (i != 0) ? 3'd4 : 3'd0;
            v.od   = (i != 0) ? words[i-1] : 32'h0;
            v.err  = 1'b0;
            apply(v);
        end
        apply('{1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0});

        for (int t = 0; t < 5 && sb.size() != 0; t++) @(negedge clk);
        #4;
        if (sb.size() != 0) begin
            n_miscmp++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
